register_file_arbiter: RTL and testbench
========================================

# register_file_arbiter

Shares the single read/write port A of the 64 x 16-bit register file between several requesters (e.g. instruction datapath, debug/DMA engine). It arbitrates round-robin, registers the winning command into a one-stage access pipeline driving AddressA/WriteData/WriteEnable, and returns read data to the owner. A lock mechanism gives one requester exclusive access for read-modify-write, with an idle timeout. Port B is not touched by this block.

## Interface
Parameters:
- NumRequesters, 2, number of requesters (2..8)
- AddrWidth, 6, register file address width
- DataWidth, 16, register file data width
- MaxLockIdle, 15, idle cycles a lock owner may hold the lock without issuing a command

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- ReqValid  in  NumRequesters  requester i has a command
- ReqWrite  in  NumRequesters  1 = write, 0 = read
- ReqLock  in  NumRequesters  command requests/keeps lock
- ReqAddress  in  NumRequesters x AddrWidth  target register
- ReqWriteData  in  NumRequesters x DataWidth  write data
- ReqReady  out  NumRequesters  one-hot grant; handshake = ReqValid[i] & ReqReady[i]
- RespValid  out  NumRequesters  one-cycle read-data pulse to owner
- RespData  out  DataWidth  read data, valid with RespValid
- LockExpired  out  1  one-cycle pulse on lock timeout
- AddressA  out  AddrWidth  to register file
- WriteData  out  DataWidth  to register file
- WriteEnable  out  1  to register file
- ReadDataA  in  DataWidth  from register file (combinational read)

## Operation
- Reset values: ReqReady 0, RespValid 0, RespData 0, LockExpired 0, AddressA 0, WriteData 0, WriteEnable 0; state UNLOCKED, pointer 0, stage empty, idle counter 0.
- States: UNLOCKED, LOCKED (with LockOwner).
- UNLOCKED: winner = first i with ReqValid[i], searching from pointer upward, wrapping at NumRequesters. ReqReady is combinational: only winner bit high; all 0 if no ReqValid. On handshake, pointer <= winner+1 (mod NumRequesters).
- Handshake with ReqLock=1 in UNLOCKED -> LOCKED, LockOwner = winner, idle counter 0.
- LOCKED: ReqReady[LockOwner] = ReqValid[LockOwner]; all other bits 0. Handshake with ReqLock=0 -> UNLOCKED (that command still executes). Pointer unchanged while LOCKED; on unlock pointer <= LockOwner+1.
- Idle counter increments each LOCKED cycle without owner handshake, clears on handshake. Reaching MaxLockIdle -> UNLOCKED, LockExpired pulses next cycle, pointer <= LockOwner+1.
- Accepted command is registered into the access stage; stage drives port A for exactly one cycle. WriteEnable = stage valid & write. Empty stage: WriteEnable 0, AddressA/WriteData hold last values.
- Read: ReadDataA captured at end of access cycle; RespValid[owner] and RespData asserted next cycle. Writes produce no response.

## Timing
- Throughput: one command per cycle (back-to-back grants allowed).
- Handshake at edge t -> port A driven in cycle t+1 -> register written at edge t+2 (write) / RespValid high in cycle t+2 (read).
- Read after write to same address, back-to-back: read sees new data (write commits before read's access cycle ends).
- Simultaneous lock-timeout and owner handshake: handshake wins, counter clears.
- Reset mid-operation: stage emptied, WriteEnable falls immediately (async), pending response dropped, lock released.

## Structure
- Package register_file_pkg: AddrWidth/DataWidth constants, rf_cmd_t struct (write, lock, address, data), arbiter state enum.
- Sub-module rr_arbiter: combinational round-robin picker (request vector + pointer -> one-hot grant, winner index).

## Test plan
- Reset: all outputs 0; assert Reset during a write access cycle -> WriteEnable drops same cycle, no later RespValid.
- Requester 0 writes 0x1FF4 to 0x0B, then reads 0x0B -> WriteEnable one cycle, RespValid[0] with RespData 0x1FF4 two cycles after read handshake.
- Requesters 0 and 1 request continuously (writes 0x1234 to 0x09, 0x0041 to 0x3B) -> grants alternate 0,1,0,1; both registers hold final values.
- Requester 1 locks: read 0x09, then write 0x1235 with ReqLock=0 while requester 0 requests -> requester 0 granted only after unlock.
- Requester 1 locks then idles 15 cycles -> LockExpired pulse, requester 0 granted next cycle.
- Back-to-back write 0x0040 then read of 0x0B -> RespData 0x0040.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and widths for the register-file port-A arbiter.
package register_file_pkg;

    localparam int RF_ADDR_W = 6;
    localparam int RF_DATA_W = 16;

    typedef struct packed {
        logic                 write;
        logic                 lock;
        logic [RF_ADDR_W-1:0] address;
        logic [RF_DATA_W-1:0] data;
    } rf_cmd_t;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the pointer, wrapping.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int IdxW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] winner_o
);

    logic found_s;
    int   idx_s;

    // Scan from the pointer upward; the first asserted request wins.
    always_comb begin
        grant_o  = '0;
        winner_o = ptr_i;
        found_s  = 1'b0;
        idx_s    = 0;
        for (int off = 0; off < N; off++) begin
            idx_s = int'(ptr_i) + off;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_i[idx_s]) begin
                found_s         = 1'b1;
                grant_o[idx_s]  = 1'b1;
                winner_o        = IdxW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/register_file_arbiter.sv
// Round-robin owner of register-file port A with a one-stage access pipeline,
// read-data return and a lock for read-modify-write with an idle timeout.
module register_file_arbiter
    import register_file_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int AddrWidth     = RF_ADDR_W,
    parameter int DataWidth     = RF_DATA_W,
    parameter int MaxLockIdle   = 15
) (
    input  logic                                    Clock,
    input  logic                                    Reset,
    input  logic [NumRequesters-1:0]                ReqValid,
    input  logic [NumRequesters-1:0]                ReqWrite,
    input  logic [NumRequesters-1:0]                ReqLock,
    input  logic [NumRequesters-1:0][AddrWidth-1:0] ReqAddress,
    input  logic [NumRequesters-1:0][DataWidth-1:0] ReqWriteData,
    output logic [NumRequesters-1:0]                ReqReady,
    output logic [NumRequesters-1:0]                RespValid,
    output logic [DataWidth-1:0]                    RespData,
    output logic                                    LockExpired,
    output logic [AddrWidth-1:0]                    AddressA,
    output logic [DataWidth-1:0]                    WriteData,
    output logic                                    WriteEnable,
    input  logic [DataWidth-1:0]                    ReadDataA
);

    localparam int IdxW  = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
    localparam int IdleW = $clog2(MaxLockIdle + 1);

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        if (int'(i) == NumRequesters - 1) begin
            return '0;
        end else begin
            return i + 1'b1;
        end
    endfunction

    arb_state_e                 state_q, state_d;
    logic [IdxW-1:0]            owner_q, owner_d;
    logic [IdxW-1:0]            ptr_q, ptr_d;
    logic [IdleW-1:0]           idle_q, idle_d;
    logic                       expired_q, expired_d;
    logic                       stage_vld_q, stage_vld_d;
    logic                       stage_wr_q, stage_wr_d;
    logic [AddrWidth-1:0]       stage_addr_q, stage_addr_d;
    logic [DataWidth-1:0]       stage_data_q, stage_data_d;
    logic [IdxW-1:0]            stage_own_q, stage_own_d;
    logic [NumRequesters-1:0]   resp_vld_q, resp_vld_d;
    logic [DataWidth-1:0]       resp_data_q, resp_data_d;

    logic [NumRequesters-1:0]   arb_grant_s;
    logic [IdxW-1:0]            arb_winner_s;
    logic [NumRequesters-1:0]   ready_s;
    logic [IdxW-1:0]            sel_s;
    logic                       hs_s;
    rf_cmd_t                    cmd_s;

    rr_arbiter #(
        .N    (NumRequesters),
        .IdxW (IdxW)
    ) u_rr (
        .req_i    (ReqValid),
        .ptr_i    (ptr_q),
        .grant_o  (arb_grant_s),
        .winner_o (arb_winner_s)
    );

    // While locked only the owner can be granted; otherwise the round-robin pick.
    always_comb begin
        ready_s = '0;
        sel_s   = arb_winner_s;
        if (state_q == ARB_LOCKED) begin
            sel_s            = owner_q;
            ready_s[owner_q] = ReqValid[owner_q];
        end else begin
            ready_s = arb_grant_s;
        end
        hs_s          = |(ReqValid & ready_s);
        cmd_s.write   = ReqWrite[sel_s];
        cmd_s.lock    = ReqLock[sel_s];
        cmd_s.address = ReqAddress[sel_s];
        cmd_s.data    = ReqWriteData[sel_s];
    end

    // Lock FSM, round-robin pointer and idle timeout; an owner handshake beats the timeout.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        idle_d    = idle_q;
        expired_d = 1'b0;
        case (state_q)
            ARB_UNLOCKED: begin
                if (hs_s) begin
                    ptr_d = next_idx(sel_s);
                    if (cmd_s.lock) begin
                        state_d = ARB_LOCKED;
                        owner_d = sel_s;
                        idle_d  = '0;
                    end else begin
                        state_d = ARB_UNLOCKED;
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ARB_LOCKED: begin
                if (hs_s) begin
                    idle_d = '0;
                    if (!cmd_s.lock) begin
                        state_d = ARB_UNLOCKED;
                        ptr_d   = next_idx(owner_q);
                    end else begin
                        state_d = ARB_LOCKED;
                    end
                end else if (idle_q == IdleW'(MaxLockIdle - 1)) begin
                    state_d   = ARB_UNLOCKED;
                    ptr_d     = next_idx(owner_q);
                    idle_d    = '0;
                    expired_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_UNLOCKED;
                idle_d  = '0;
            end
        endcase
    end

    // Access stage loads only on a handshake so port A holds its last values when idle.
    always_comb begin
        stage_vld_d  = hs_s;
        stage_wr_d   = stage_wr_q;
        stage_addr_d = stage_addr_q;
        stage_data_d = stage_data_q;
        stage_own_d  = stage_own_q;
        if (hs_s) begin
            stage_wr_d   = cmd_s.write;
            stage_addr_d = cmd_s.address;
            stage_data_d = cmd_s.data;
            stage_own_d  = sel_s;
        end else begin
            stage_wr_d = stage_wr_q;
        end
        resp_vld_d  = '0;
        resp_data_d = resp_data_q;
        if (stage_vld_q && !stage_wr_q) begin
            resp_vld_d[stage_own_q] = 1'b1;
            resp_data_d             = ReadDataA;
        end else begin
            resp_data_d = resp_data_q;
        end
    end

    // State registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ARB_UNLOCKED;
            owner_q      <= '0;
            ptr_q        <= '0;
            idle_q       <= '0;
            expired_q    <= 1'b0;
            stage_vld_q  <= 1'b0;
            stage_wr_q   <= 1'b0;
            stage_addr_q <= '0;
            stage_data_q <= '0;
            stage_own_q  <= '0;
            resp_vld_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            idle_q       <= idle_d;
            expired_q    <= expired_d;
            stage_vld_q  <= stage_vld_d;
            stage_wr_q   <= stage_wr_d;
            stage_addr_q <= stage_addr_d;
            stage_data_q <= stage_data_d;
            stage_own_q  <= stage_own_d;
            resp_vld_q   <= resp_vld_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign ReqReady    = ready_s;
    assign RespValid   = resp_vld_q;
    assign RespData    = resp_data_q;
    assign LockExpired = expired_q;
    assign AddressA    = stage_addr_q;
    assign WriteData   = stage_data_q;
    assign WriteEnable = stage_vld_q & stage_wr_q;

endmodule

// File: tb/tb_register_file_arbiter.sv
// Scoreboard bench for register_file_arbiter with a behavioural 64x16 register file on port A.
module tb_register_file_arbiter;

    localparam int N  = 2;
    localparam int AW = 6;
    localparam int DW = 16;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic [N-1:0]         ReqValid, ReqWrite, ReqLock;
    logic [N-1:0][AW-1:0] ReqAddress;
    logic [N-1:0][DW-1:0] ReqWriteData;
    logic [N-1:0]         ReqReady, RespValid;
    logic [DW-1:0]        RespData, WriteData, ReadDataA;
    logic                 LockExpired, WriteEnable;
    logic [AW-1:0]        AddressA;

    register_file_arbiter #(
        .NumRequesters (N), .AddrWidth (AW), .DataWidth (DW), .MaxLockIdle (15)
    ) dut (
        .Clock (Clock), .Reset (Reset),
        .ReqValid (ReqValid), .ReqWrite (ReqWrite), .ReqLock (ReqLock),
        .ReqAddress (ReqAddress), .ReqWriteData (ReqWriteData),
        .ReqReady (ReqReady), .RespValid (RespValid), .RespData (RespData),
        .LockExpired (LockExpired), .AddressA (AddressA), .WriteData (WriteData),
        .WriteEnable (WriteEnable), .ReadDataA (ReadDataA)
    );

    always #5 Clock = ~Clock;

    logic [DW-1:0] rf_mem  [64];
    logic [DW-1:0] ref_mem [64];
    always @(posedge Clock) if (WriteEnable) rf_mem[AddressA] <= WriteData;
    assign ReadDataA = rf_mem[AddressA];

    typedef struct { int rid; logic [DW-1:0] data; int cyc; } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    int   grant_log[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: pop responses, then record this cycle's handshakes into the model.
    always @(negedge Clock) begin
        cyc++;
        if (Reset) begin
            sb_q.delete();
        end else begin
            if (RespValid != '0) begin
                if (sb_q.size() == 0) begin
                    check_eq("resp_unexpected", 32'(RespValid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("resp_owner", 32'(RespValid), 32'd1 << mon_e.rid);
                    check_eq("resp_data", 32'(RespData), 32'(mon_e.data));
                    check_eq("resp_latency", 32'(cyc - mon_e.cyc), 32'd2);
                end
            end
            check_eq("ready_onehot0", 32'($onehot0(ReqReady)), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (ReqValid[i] && ReqReady[i]) begin
                    grant_log.push_back(i);
                    if (ReqWrite[i]) ref_mem[ReqAddress[i]] = ReqWriteData[i];
                    else sb_q.push_back('{rid: i, data: ref_mem[ReqAddress[i]], cyc: cyc});
                end
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input bit wr, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        ReqValid[r] = v; ReqWrite[r] = wr; ReqLock[r] = lk;
        ReqAddress[r] = a; ReqWriteData[r] = d;
    endtask

    task automatic send(input int r, input bit wr, input bit lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        set_req(r, 1'b1, wr, lk, a, d);
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            got = ReqReady[r];
            step();
            if (got) break;
        end
        ReqValid[r] = 1'b0;
        check_eq("send_grant", 32'(got), 32'd1);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin rf_mem[i] = '0; ref_mem[i] = '0; end
        Reset = 1'b1; ReqValid = '0; ReqWrite = '0; ReqLock = '0;
        ReqAddress = '0; ReqWriteData = '0;
        repeat (2) @(negedge Clock);
        check_eq("rst_ready", 32'(ReqReady), 32'd0);
        check_eq("rst_resp_valid", 32'(RespValid), 32'd0);
        check_eq("rst_resp_data", 32'(RespData), 32'd0);
        check_eq("rst_lock_expired", 32'(LockExpired), 32'd0);
        check_eq("rst_address", 32'(AddressA), 32'd0);
        check_eq("rst_wdata", 32'(WriteData), 32'd0);
        check_eq("rst_we", 32'(WriteEnable), 32'd0);
        step();
        Reset = 1'b0;
        step();

        // Write then read from requester 0
        send(0, 1'b1, 1'b0, 6'h0B, 16'h1FF4);
        @(negedge Clock);
        check_eq("wr_we", 32'(WriteEnable), 32'd1);
        check_eq("wr_addr", 32'(AddressA), 32'h0B);
        check_eq("wr_data", 32'(WriteData), 32'h1FF4);
        step();
        @(negedge Clock);
        check_eq("wr_we_one_cycle", 32'(WriteEnable), 32'd0);
        check_eq("addr_hold", 32'(AddressA), 32'h0B);
        step();
        send(0, 1'b0, 1'b0, 6'h0B, 16'h0000);
        repeat (4) step();
        check_eq("rf_0b", 32'(rf_mem[11]), 32'h1FF4);

        // Two continuous requesters alternate from pointer 0
        pulse_reset();
        grant_log.delete();
        set_req(0, 1'b1, 1'b1, 1'b0, 6'h09, 16'h1234);
        set_req(1, 1'b1, 1'b1, 1'b0, 6'h3B, 16'h0041);
        repeat (4) step();
        ReqValid = '0;
        repeat (3) step();
        check_eq("alt_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < grant_log.size()) check_eq("alt_grant", 32'(grant_log[k]), 32'(k % 2));
        check_eq("rf_09", 32'(rf_mem[9]), 32'h1234);
        check_eq("rf_3b", 32'(rf_mem[59]), 32'h0041);

        // Requester 1 lock: requester 0 waits until the unlocking write
        grant_log.delete();
        set_req(1, 1'b1, 1'b0, 1'b1, 6'h09, 16'h0000);
        @(negedge Clock);
        check_eq("lock_grant", 32'(ReqReady), 32'b10);
        step();
        ReqValid[1] = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 6'h3B, 16'h0000);
        repeat (2) begin
            @(negedge Clock);
            check_eq("locked_block", 32'(ReqReady), 32'd0);
            step();
        end
        set_req(1, 1'b1, 1'b1, 1'b0, 6'h09, 16'h1235);
        @(negedge Clock);
        check_eq("unlock_cmd", 32'(ReqReady), 32'b10);
        step();
        ReqValid[1] = 1'b0;
        @(negedge Clock);
        check_eq("post_unlock", 32'(ReqReady), 32'b01);
        step();
        ReqValid[0] = 1'b0;
        repeat (4) step();
        check_eq("lock_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check_eq("lock_order0", 32'(grant_log[0]), 32'd1);
            check_eq("lock_order1", 32'(grant_log[1]), 32'd1);
            check_eq("lock_order2", 32'(grant_log[2]), 32'd0);
        end
        check_eq("rf_09_rmw", 32'(rf_mem[9]), 32'h1235);

        // Lock idle timeout after 15 cycles
        set_req(1, 1'b1, 1'b0, 1'b1, 6'h3B, 16'h0000);
        @(negedge Clock);
        check_eq("to_lock_grant", 32'(ReqReady), 32'b10);
        step();
        ReqValid[1] = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 6'h09, 16'h0000);
        for (int k = 1; k <= 15; k++) begin
            @(negedge Clock);
            check_eq("idle_block", 32'(ReqReady), 32'd0);
            check_eq("no_expire", 32'(LockExpired), 32'd0);
            step();
        end
        @(negedge Clock);
        check_eq("lock_expired", 32'(LockExpired), 32'd1);
        check_eq("expire_grant", 32'(ReqReady), 32'b01);
        step();
        ReqValid[0] = 1'b0;
        @(negedge Clock);
        check_eq("expire_pulse", 32'(LockExpired), 32'd0);
        repeat (3) step();

        // Back-to-back write then read of the same register
        send(0, 1'b1, 1'b0, 6'h0B, 16'h0040);
        send(0, 1'b0, 1'b0, 6'h0B, 16'h0000);
        repeat (4) step();

        // Reset during a read access drops its response
        send(0, 1'b0, 1'b0, 6'h0B, 16'h0000);
        #2;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            check_eq("drop_resp", 32'(RespValid), 32'd0);
            step();
        end

        // Reset during a write access drops WriteEnable immediately
        send(0, 1'b1, 1'b0, 6'h20, 16'hBEEF);
        #1;
        check_eq("we_before_rst", 32'(WriteEnable), 32'd1);
        Reset = 1'b1;
        #1;
        check_eq("we_async_drop", 32'(WriteEnable), 32'd0);
        check_eq("addr_async_rst", 32'(AddressA), 32'd0);
        step();
        Reset = 1'b0;
        repeat (3) step();
        check_eq("no_commit", 32'(rf_mem[32]), 32'd0);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
